// File: rtl/rv_types.sv
// rv_types: shared states, termination causes and opcode/syscall constants for rv_sim_ctl.
package rv_types;
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {C_NONE, C_EXIT, C_EBREAK, C_TIMEOUT} cause_t;
    localparam logic [31:0] OP_ECALL  = 32'h0000_0073;
    localparam logic [31:0] OP_EBREAK = 32'h0010_0073;
    localparam int          SYS_WRITE = 64;
endpackage

// File: rtl/rv_sat_counter.sv
// rv_sat_counter: up-counter with synchronous clear that sticks at all-ones.
module rv_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && q != '1)
            q <= q + W'(1);
    end
endmodule

// File: rtl/rv_sim_ctl.sv
// rv_sim_ctl: watches the issue stream for exit/ebreak/watchdog and raises a sticky done after a drain delay.
// Define RV_SIM_CTL_PUTCHAR_EN to turn write-syscall ecalls (a7==64) into a console byte strobe.
module rv_sim_ctl
    import rv_types::*;
#(
    parameter int XLEN       = 32,
    parameter int SYS_EXIT   = 93,
    parameter int EXIT_DELAY = 5,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic             clk,
    input  logic             xreset,
    input  logic             ir_valid,
    input  logic [31:0]      ir,
    input  logic [XLEN-1:0]  a7,
    input  logic [XLEN-1:0]  a0,
    output logic             done,
    output logic [1:0]       cause,
    output logic [XLEN-1:0]  exit_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] ecall_count,
    output logic             char_valid,
    output logic [7:0]       char_data
);
    localparam int DW = (EXIT_DELAY > 1) ? $clog2(EXIT_DELAY) : 1;

    state_t        state, next_state;
    cause_t        cause_n;
    logic [DW-1:0] dcnt;
    logic          prev_ecall, prev_ebreak;
    logic          hit_ecall, hit_ebreak, new_ecall, new_ebreak;
    logic          is_exit, timeout_hit, stop, run;

    // A stalled instruction is held on the bus; only its first cycle is an event.
    assign hit_ecall   = ir_valid && ir == OP_ECALL;
    assign hit_ebreak  = ir_valid && ir == OP_EBREAK;
    assign new_ecall   = hit_ecall && !prev_ecall;
    assign new_ebreak  = hit_ebreak && !prev_ebreak;
    assign is_exit     = new_ecall && a7 == XLEN'(SYS_EXIT);
    assign timeout_hit = (TIMEOUT != 0) && cycle_count == CNT_W'(TIMEOUT - 1);
    assign stop        = is_exit || new_ebreak || timeout_hit;
    assign run         = state == RUN;
    assign cause_n     = is_exit ? C_EXIT : new_ebreak ? C_EBREAK : C_TIMEOUT;

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = (run && stop) ? ((EXIT_DELAY == 0) ? DONE : DRAIN)
                   : (state == DRAIN && dcnt == '0) ? DONE : state;
    end

    always_comb begin
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            prev_ecall  <= 1'b0;
            prev_ebreak <= 1'b0;
            dcnt        <= '0;
            cause       <= C_NONE;
            exit_code   <= '0;
        end else begin
            prev_ecall  <= hit_ecall;
            prev_ebreak <= hit_ebreak;
            if (run && stop) begin
                cause     <= cause_n;
                exit_code <= is_exit ? a0 : '0;
                dcnt      <= DW'((EXIT_DELAY > 0) ? EXIT_DELAY - 1 : 0);
            end else if (state == DRAIN && dcnt != '0) begin
                dcnt <= dcnt - DW'(1);
            end
        end
    end

    rv_sat_counter #(.W(CNT_W)) u_cycle (
        .clk   (clk),
        .rst_n (xreset),
        .clr   (1'b0),
        .inc   (run),
        .q     (cycle_count)
    );

    rv_sat_counter #(.W(CNT_W)) u_ecall (
        .clk   (clk),
        .rst_n (xreset),
        .clr   (1'b0),
        .inc   (run && new_ecall),
        .q     (ecall_count)
    );

`ifdef RV_SIM_CTL_PUTCHAR_EN
    always_ff @(posedge clk or negedge xreset) begin
        if (!xreset) begin
            char_valid <= 1'b0;
            char_data  <= '0;
        end else begin
            char_valid <= run && new_ecall && a7 == XLEN'(SYS_WRITE);
            if (run && new_ecall && a7 == XLEN'(SYS_WRITE))
                char_data <= a0[7:0];
        end
    end
`else
    assign char_valid = 1'b0;
    assign char_data  = '0;
`endif
endmodule

// File: tb/tb_rv_sim_ctl.sv
// tb_rv_sim_ctl: directed run of rv_sim_ctl (TIMEOUT=100, EXIT_DELAY=5) with a queue of expected terminations.
module tb_rv_sim_ctl;
    logic        clk = 1'b0;
    logic        xreset = 1'b1;
    logic        ir_valid = 1'b0;
    logic [31:0] ir = '0, a7 = '0, a0 = '0;
    logic        done, char_valid;
    logic [1:0]  cause;
    logic [31:0] exit_code, cycle_count, ecall_count;
    logic [7:0]  char_data;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] code;
        logic [31:0] cyc;
        logic [31:0] ec;
        int          edge_n;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   n_edges = 0;

    rv_sim_ctl #(.TIMEOUT(100)) dut (
        .clk         (clk),
        .xreset      (xreset),
        .ir_valid    (ir_valid),
        .ir          (ir),
        .a7          (a7),
        .a0          (a0),
        .done        (done),
        .cause       (cause),
        .exit_code   (exit_code),
        .cycle_count (cycle_count),
        .ecall_count (ecall_count),
        .char_valid  (char_valid),
        .char_data   (char_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        n_edges++;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] s7, input logic [31:0] s0, input int hold);
        ir_valid = 1'b1;
        ir = i;
        a7 = s7;
        a0 = s0;
        repeat (hold) step();
        ir_valid = 1'b0;
        ir = '0;
        a7 = '0;
        a0 = '0;
    endtask

    task automatic do_reset();
        xreset = 1'b0;
        ir_valid = 1'b0;
        ir = '0;
        step();
        step();
        check("rst_done", done, 0);
        check("rst_cause", cause, 0);
        check("rst_code", exit_code, 0);
        check("rst_cyc", cycle_count, 0);
        check("rst_ecall", ecall_count, 0);
        xreset = 1'b1;
        n_edges = 0;
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        for (int i = 0; i < 300 && !done; i++) step();
        check({tag, "_done"}, done, 1);
        e = sb.pop_front();
        check({tag, "_edge"}, n_edges, e.edge_n);
        check({tag, "_cause"}, cause, e.cause);
        check({tag, "_code"}, exit_code, e.code);
        check({tag, "_cyc"}, cycle_count, e.cyc);
        check({tag, "_ecall"}, ecall_count, e.ec);
    endtask

    initial begin
        #2;
        do_reset();

        // exit at edge 3, done 5 edges later, then stays put
        repeat (2) step();
        sb.push_back('{cause: 2'd1, code: 32'd7, cyc: 32'd3, ec: 32'd1, edge_n: 8});
        issue(32'h73, 32'd93, 32'd7, 1);
        check("t1_drain", done, 0);
        wait_done("t1");
        repeat (3) step();
        check("t1_sticky", done, 1);
        check("t1_frozen", cycle_count, 3);

        // exit held through a 4-cycle stall counts once, timed from the first cycle
        do_reset();
        step();
        sb.push_back('{cause: 2'd1, code: 32'd3, cyc: 32'd2, ec: 32'd1, edge_n: 7});
        issue(32'h73, 32'd93, 32'd3, 4);
        wait_done("t2");

        // plain ecalls only count; ebreak wins; later exit in drain ignored
        do_reset();
        issue(32'h73, 32'd1, 32'd0, 2);
        step();
        issue(32'h73, 32'd1, 32'd0, 1);
        check("t4_run", done, 0);
        check("t4_ecalls", ecall_count, 2);
        sb.push_back('{cause: 2'd2, code: 32'd0, cyc: 32'd5, ec: 32'd2, edge_n: 10});
        issue(32'h0010_0073, 32'd0, 32'd0, 1);
        issue(32'h73, 32'd93, 32'd9, 1);
        wait_done("t4");

        // exit on the same edge the watchdog would fire
        do_reset();
        repeat (99) step();
        sb.push_back('{cause: 2'd1, code: 32'd5, cyc: 32'd100, ec: 32'd1, edge_n: 105});
        issue(32'h73, 32'd93, 32'd5, 1);
        wait_done("t3a");

        // idle run hits the watchdog
        do_reset();
        sb.push_back('{cause: 2'd3, code: 32'd0, cyc: 32'd100, ec: 32'd0, edge_n: 105});
        wait_done("t3b");

        // reset in the middle of a drain, then a clean exit
        do_reset();
        step();
        issue(32'h73, 32'd93, 32'h55, 1);
        step();
        step();
        check("t5_mid_cause", cause, 1);
        check("t5_mid_code", exit_code, 32'h55);
        check("t5_mid_done", done, 0);
        do_reset();
        sb.push_back('{cause: 2'd1, code: 32'd11, cyc: 32'd1, ec: 32'd1, edge_n: 6});
        issue(32'h73, 32'd93, 32'd11, 1);
        wait_done("t5");

        // write syscall
        do_reset();
        issue(32'h73, 32'd64, 32'h141, 1);
`ifdef RV_SIM_CTL_PUTCHAR_EN
        check("t6_cv", char_valid, 1);
        check("t6_cd", char_data, 8'h41);
        step();
        check("t6_cv_pulse", char_valid, 0);
`else
        check("t6_cv", char_valid, 0);
        check("t6_cd", char_data, 0);
        step();
`endif
        check("t6_run", done, 0);
        check("t6_ecall", ecall_count, 1);
        check("t6_cause", cause, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
